// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared opcode values, FSM state encoding and the default
//               operand width for the ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

  localparam int DEFAULT_BITS = 16;

  typedef enum logic [2:0] {
    ADD        = 3'd0,
    SUB        = 3'd1,
    MULT       = 3'd2,
    SHIFT_LEFT = 3'd3,
    AND        = 3'd4,
    OR         = 3'd5,
    XOR        = 3'd6,
    NOT        = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_CLEAR = 3'd4
  } arb_state_e;

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Requester request/response channels plus the ALU-side bus
//               of the two-requester ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int BITS = alu_arbiter_pkg::DEFAULT_BITS
);
  import alu_arbiter_pkg::*;

  logic            req0_valid;
  logic            req0_ready;
  logic [BITS-1:0] req0_a;
  logic [BITS-1:0] req0_b;
  logic [2:0]      req0_op;
  logic            req1_valid;
  logic            req1_ready;
  logic [BITS-1:0] req1_a;
  logic [BITS-1:0] req1_b;
  logic [2:0]      req1_op;

  logic            rsp0_valid;
  logic [BITS-1:0] rsp0_data;
  logic            rsp0_err;
  logic            rsp1_valid;
  logic [BITS-1:0] rsp1_data;
  logic            rsp1_err;

  logic            alu_rst;
  logic [BITS-1:0] alu_a;
  logic [BITS-1:0] alu_b;
  logic [2:0]      alu_op;
  logic [BITS-1:0] alu_out;
  logic            alu_status;

  logic            busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_out, alu_status,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_err,
    output rsp1_valid, rsp1_data, rsp1_err,
    output alu_rst, alu_a, alu_b, alu_op, busy
  );

  // Requesters plus the external ALU
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_out, alu_status,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_err,
    input  rsp1_valid, rsp1_data, rsp1_err,
    input  alu_rst, alu_a, alu_b, alu_op, busy
  );

endinterface : alu_arbiter_if
`default_nettype wire

// File: rtl/alu_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_picker
// Description : Two-way one-hot grant; ptr=1 gives requester 1 priority when
//               both are valid, a lone valid requester always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_picker (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       ptr,
  output logic [1:0] grant
);
  import alu_arbiter_pkg::*;

  assign grant[0] = valid0 && (!valid1 || !ptr);
  assign grant[1] = valid1 && (!valid0 ||  ptr);

endmodule : alu_rr_picker
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Serialises two requesters onto one external registered ALU
//               with fixed 3-cycle latency and an ALU reset after errors.
//               ALU_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed
//               req0 priority.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int BITS = alu_arbiter_pkg::DEFAULT_BITS
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  import alu_arbiter_pkg::*;

  arb_state_e      r_state;
  arb_state_e      w_next;
  logic            r_owner;
  logic [BITS-1:0] r_alu_a;
  logic [BITS-1:0] r_alu_b;
  logic [2:0]      r_alu_op;
  logic [BITS-1:0] r_result;
  logic            r_err;
  logic            w_ptr;
  logic [1:0]      w_grant;
  logic            w_accept;
  logic            w_resp;

  alu_rr_picker u_picker (
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .ptr    (w_ptr),
    .grant  (w_grant)
  );

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= ~w_grant[1];
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.busy       = 1'b1;
    bus.alu_rst    = rst;
    case (r_state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (!rst) begin
          bus.req0_ready = w_grant[0];
          bus.req1_ready = w_grant[1];
          if (|w_grant) begin
            w_next = ST_EXEC;
          end
        end
      end
      ST_EXEC:  w_next = ST_CAPT;
      ST_CAPT:  w_next = ST_RESP;
      ST_RESP:  w_next = r_err ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: begin
        bus.alu_rst = 1'b1;
        w_next      = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_accept = bus.req0_ready | bus.req1_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= 1'b0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= 3'd0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner  <= w_grant[1];
        r_alu_a  <= w_grant[1] ? bus.req1_a  : bus.req0_a;
        r_alu_b  <= w_grant[1] ? bus.req1_b  : bus.req0_b;
        r_alu_op <= w_grant[1] ? bus.req1_op : bus.req0_op;
      end else if ((r_state == ST_RESP) && r_err) begin
        // Park neutral operands so a sticky ALU cannot re-raise its error
        // from the failing operation after the clear pulse.
        r_alu_a  <= '0;
        r_alu_b  <= '0;
        r_alu_op <= 3'd0;
      end
      if (r_state == ST_CAPT) begin
        r_result <= bus.alu_out;
        r_err    <= bus.alu_status;
      end
    end
  end

  assign bus.alu_a  = r_alu_a;
  assign bus.alu_b  = r_alu_b;
  assign bus.alu_op = r_alu_op;

  assign w_resp         = (r_state == ST_RESP);
  assign bus.rsp0_valid = w_resp && !r_owner;
  assign bus.rsp1_valid = w_resp &&  r_owner;
  assign bus.rsp0_err   = bus.rsp0_valid && r_err;
  assign bus.rsp1_err   = bus.rsp1_valid && r_err;
  assign bus.rsp0_data  = (bus.rsp0_valid && !r_err) ? r_result : '0;
  assign bus.rsp1_data  = (bus.rsp1_valid && !r_err) ? r_result : '0;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with a small
//               registered ALU model; honours ALU_ARB_ROUND_ROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int BITS = 16;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit c_rr = 1'b1;
`else
  localparam bit c_rr = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_arbiter_if #(.BITS(BITS)) bus ();

  alu_arbiter #(.BITS(BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Registered ALU with a sticky overflow flag cleared only by alu_rst
  logic [2*BITS-1:0] w_prod;
  logic [BITS-1:0]   w_res;
  assign w_prod = {{BITS{1'b0}}, bus.alu_a} * {{BITS{1'b0}}, bus.alu_b};

  always_comb begin
    w_res = '0;
    case (bus.alu_op)
      ADD:        w_res = bus.alu_a + bus.alu_b;
      SUB:        w_res = bus.alu_a - bus.alu_b;
      MULT:       w_res = w_prod[BITS-1:0];
      SHIFT_LEFT: w_res = bus.alu_a << bus.alu_b;
      AND:        w_res = bus.alu_a & bus.alu_b;
      OR:         w_res = bus.alu_a | bus.alu_b;
      XOR:        w_res = bus.alu_a ^ bus.alu_b;
      default:    w_res = ~bus.alu_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.alu_rst) begin
      bus.alu_out    <= '0;
      bus.alu_status <= 1'b0;
    end else begin
      bus.alu_out    <= w_res;
      bus.alu_status <= bus.alu_status |
                        ((bus.alu_op == MULT) && (w_prod[2*BITS-1:BITS] != '0));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int n, input logic v, input logic [BITS-1:0] a,
                       input logic [BITS-1:0] b, input logic [2:0] op);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  function automatic logic rdy(input int n);
    return (n == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rspv(input int n);
    return (n == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  task automatic issue(input string tag, input int n, input logic [BITS-1:0] a,
                       input logic [BITS-1:0] b, input logic [2:0] op);
    drive(n, 1'b1, a, b, op);
    #1;
    check({tag, "_ready"}, 32'(rdy(n)), 32'd1);
  endtask

  // Called in the accept cycle; returns at the negedge one cycle after the pulse.
  task automatic wait_rsp(input string tag, input int n, input bit drop,
                          input logic [BITS-1:0] exp_d, input logic exp_e);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (drop) begin
          if (n == 0) bus.req0_valid = 1'b0;
          else        bus.req1_valid = 1'b0;
        end
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_noready"}, 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      end
    end while (!rspv(n) && lat < 12);
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_data"}, 32'((n == 0) ? bus.rsp0_data : bus.rsp1_data), 32'(exp_d));
    check({tag, "_err"}, 32'((n == 0) ? bus.rsp0_err : bus.rsp1_err), 32'(exp_e));
    check({tag, "_other"}, 32'(rspv(1 - n)), 32'd0);
    check({tag, "_alurst_resp"}, 32'(bus.alu_rst), 32'd0);
    @(negedge clk);
    check({tag, "_onepulse"}, 32'(rspv(n)), 32'd0);
  endtask

  task automatic apply_reset();
    drive(0, 1'b0, '0, '0, 3'd0);
    drive(1, 1'b0, '0, '0, 3'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int pulses;
    int exp_g;
    drive(1, 1'b0, '0, '0, 3'd0);
    drive(0, 1'b1, 16'd5, 16'd5, ADD);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_alu_rst", 32'(bus.alu_rst), 32'd1);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_rsp0", 32'({bus.rsp0_valid, bus.rsp0_err, bus.rsp0_data}), 32'd0);
    drive(0, 1'b0, '0, '0, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_alu_rst", 32'(bus.alu_rst), 32'd0);

    issue("add", 0, 16'd33, 16'd45, ADD);
    wait_rsp("add", 0, 1'b1, 16'd78, 1'b0);
    check("add_idle", 32'(bus.busy), 32'd0);

    apply_reset();
    drive(0, 1'b1, 16'd12, 16'd12, MULT);
    drive(1, 1'b1, 16'd3855, 16'd13107, AND);
    #1;
    check("both_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
    wait_rsp("mult", 0, 1'b1, 16'd144, 1'b0);
    #1;
    check("and_ready", 32'(rdy(1)), 32'd1);
    wait_rsp("and", 1, 1'b1, 16'd771, 1'b0);

    apply_reset();
    issue("ovf", 1, 16'd9999, 16'd9999, MULT);
    wait_rsp("ovf", 1, 1'b1, 16'd0, 1'b1);
    drive(1, 1'b1, 16'd10, 16'd1, SHIFT_LEFT);
    #1;
    check("clr_alu_rst", 32'(bus.alu_rst), 32'd1);
    check("clr_busy", 32'(bus.busy), 32'd1);
    check("clr_ready", 32'(rdy(1)), 32'd0);
    @(negedge clk);
    #1;
    check("postclr_alu_rst", 32'(bus.alu_rst), 32'd0);
    check("shl_ready", 32'(rdy(1)), 32'd1);
    wait_rsp("shl", 1, 1'b1, 16'd20, 1'b0);

    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 16'd100, 16'(k), ADD);
      drive(1, 1'b1, 16'd200, 16'(k), ADD);
      #1;
      exp_g = c_rr ? (k % 2) : 0;
      check($sformatf("contend_grant%0d", k),
            32'({bus.req1_ready, bus.req0_ready}), 32'(1 << exp_g));
      wait_rsp($sformatf("contend%0d", k), exp_g, 1'b0,
               16'((exp_g == 1 ? 200 : 100) + k), 1'b0);
    end
    drive(0, 1'b0, '0, '0, 3'd0);
    drive(1, 1'b0, '0, '0, 3'd0);

    apply_reset();
    issue("abort", 0, 16'd64, 16'd30, SUB);
    @(negedge clk);
    check("abort_exec_busy", 32'(bus.busy), 32'd1);
    drive(0, 1'b0, '0, '0, 3'd0);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_alu_rst", 32'(bus.alu_rst), 32'd1);
    check("abort_alu_bus", 32'({bus.alu_a, bus.alu_b}), 32'd0);
    check("abort_alu_op", 32'(bus.alu_op), 32'd0);
    check("abort_rsp0", 32'({bus.rsp0_valid, bus.rsp0_err, bus.rsp0_data}), 32'd0);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      pulses += int'(bus.rsp0_valid);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(bus.rsp0_valid);
    end
    check("abort_nopulse", 32'(pulses), 32'd0);
    issue("resume", 0, 16'd64, 16'd30, SUB);
    wait_rsp("resume", 0, 1'b1, 16'd34, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: BITS, 16, operand/result width.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports, per requester n in {0,1}:
- reqn_valid  input  1  operation request.
- reqn_ready  output  1  request accepted this cycle.
- reqn_a  input  BITS  operand A.
- reqn_b  input  BITS  operand B.
- reqn_op  input  3  opcode.
REQ-005 SHALL have ports, per requester n: rspn_valid  output  1  one-cycle result pulse; rspn_data  output  BITS  result; rspn_err  output  1  ALU error.
REQ-006 SHALL have ALU-side ports: alu_rst  output  1  ALU reset; alu_a and alu_b  output  BITS  operands; alu_op  output  3  opcode; alu_out  input  BITS  ALU result; alu_status  input  1  ALU error (1 = error).
REQ-007 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-008 SHALL implement FSM IDLE -> EXEC -> CAPT -> RESP -> IDLE, with RESP -> CLEAR -> IDLE when the captured error is 1.
REQ-009 In IDLE only, SHALL drive ready combinationally to the single arbitration winner among valid requesters; accept on valid&&ready.
REQ-010 On accept SHALL register the winner's a/b/op onto alu_a/alu_b/alu_op, record the owner, and enter EXEC.
- ALU inputs SHALL be held stable through EXEC and CAPT.
REQ-011 EXEC SHALL be one cycle; the ALU registers its result at the end of EXEC.
REQ-012 CAPT SHALL register alu_out and alu_status.
REQ-013 RESP SHALL assert the owner's rsp_valid for exactly one cycle.
- rsp_data SHALL be the captured result, forced to 0 when err=1.
- The non-owner rsp_valid SHALL stay 0.
REQ-014 Latency SHALL be fixed: accept in cycle T, rsp_valid in cycle T+3; the next accept SHALL be no earlier than T+4 (T+5 after an error).
REQ-015 rsp has no backpressure; requesters SHALL sample rsp on the pulse.
REQ-016 CLEAR SHALL assert alu_rst for exactly one cycle, so the ALU error state is cleared before the next operation.
REQ-017 alu_rst SHALL equal rst OR (state==CLEAR).
REQ-018 All 8 opcodes SHALL pass through unmodified; the arbiter performs no arithmetic.
REQ-019 A request deasserted before acceptance SHALL be dropped with no response.
REQ-020 Requests arriving outside IDLE SHALL see ready=0 and wait.

Reset
REQ-021 While rst is high:
- state SHALL be IDLE.
- ready, rsp_valid, rsp_data, rsp_err, alu_a, alu_b, alu_op and busy SHALL be 0.
- alu_rst SHALL be 1.
- the round-robin pointer SHALL be set so req0 wins the first contention.
REQ-022 rst asserted mid-operation SHALL abort the in-flight operation with no rsp pulse; the result is discarded.

Configuration
REQ-023 With ALU_ARB_ROUND_ROBIN_EN defined, contention SHALL grant the requester not granted most recently; the pointer updates only on accept.
REQ-024 Without ALU_ARB_ROUND_ROBIN_EN, req0 SHALL always win contention (fixed priority).
REQ-025 A lone valid requester SHALL win in both modes.

Structure
REQ-026 A shared package SHALL hold:
- opcode constants ADD, SUB, MULT, SHIFT_LEFT, AND, OR, XOR, NOT.
- FSM state encoding.
- default BITS.
REQ-027 The 2-way grant logic SHALL be one sub-module, alu_rr_picker (inputs valid0/valid1 and pointer; output one-hot grant).
REQ-028 The ALU SHALL be instantiated outside this block.

Verification
REQ-029 req0 ADD a=33 b=45 -> req0_ready in T; rsp0_valid in T+3; rsp0_data=78; rsp0_err=0.
REQ-030 Same cycle: req0 MULT 12,12 and req1 AND 3855,13107 -> rsp0 144 first, then rsp1 771, both err=0.
REQ-031 req1 MULT 9999,9999 -> rsp1_err=1, rsp1_data=0, alu_rst pulses one cycle; then req1 SHIFT_LEFT 10,1 -> rsp1_data=20, err=0.
REQ-032 Both valid held for 4 ops -> grants 0,1,0,1 with ALU_ARB_ROUND_ROBIN_EN; 0,0,0,0 without.
REQ-033 rst raised during EXEC of req0 SUB 64,30 -> no rsp0 pulse; all outputs 0, alu_rst=1; after release, the next request completes with normal latency.
